led_fade_pwm: RTL
=================

Name: led_fade_pwm

Overview:
- Downstream stage of the red LED pattern sequencer.
- Consumes the sequencer's 8-bit LED pattern and drives the physical LEDR pins.
- Adds per-LED PWM brightness and an "afterglow" fade: a lit LED turned off ramps down in brightness instead of snapping off.
- Runs on the fast board clock; the pattern input comes from the slow sequencer domain and is synchronized internally.

Parameters:
- PWM_BITS, 4, width of each brightness level; 2^PWM_BITS-1 is full-on (15 at default).
- FADE_DIV, 1024, fast-clock cycles per fade step (must be >= 2).

Ports:
- CLOCK  input  1  fast board clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- LED_IN  input  8  pattern from the sequencer; asynchronous to CLOCK.
- MAX_LEVEL  input  PWM_BITS  brightness applied to lit LEDs; synchronous to CLOCK.
- FADE_EN  input  1  1 = afterglow fade enabled; 0 = LEDs off immediately when pattern bit drops.
- LED_OUT  output  8  PWM-modulated LED drive, registered.

Behaviour:
- Reset (RESET=0, asynchronous): clear all state.
  - sync regs, level[0..7], pwm_cnt and fade prescaler all = 0.
  - LED_OUT = 8'h00, held until the first rising edge after RESET returns to 1.
- Synchronizer: two flops per bit, sync1 <= LED_IN, s <= sync1.
- PWM counter:
  - pwm_cnt counts 0 .. 2^PWM_BITS-2, then wraps to 0; period 15 cycles at default.
  - Free-running; unaffected by any input except reset.
- Fade prescaler:
  - Counts 0 .. FADE_DIV-1, then wraps.
  - fade_tick = 1 for exactly one cycle when the count equals FADE_DIV-1.
- Per-channel level[i], priority order each cycle:
  1. s[i]=1: level[i] <= MAX_LEVEL.
     - Tracks MAX_LEVEL changes on the next edge.
     - A rising s[i] mid-fade jumps straight to MAX_LEVEL.
  2. s[i]=0 and FADE_EN=0: level[i] <= 0.
  3. s[i]=0, FADE_EN=1, fade_tick=1, level[i]!=0: level[i] <= level[i]-1.
  4. Otherwise: hold. Level saturates at 0 and never wraps.
- Output: LED_OUT[i] <= (pwm_cnt < level[i]).
  - level 0 → constant 0.
  - level 2^PWM_BITS-1 → constant 1.
  - level k → high for k of every 15 cycles.
- Latency: with LED_IN[i] changing before edge 0:
  - sync1 at edge 0, s at edge 1, level at edge 2.
  - LED_OUT reflects the new level from edge 3.
  - Full-on and forced-off are therefore visible exactly at edge 3, regardless of PWM phase.
- Fade duration: from MAX_LEVEL=L to 0 takes L fade_ticks, i.e. between (L-1)*FADE_DIV+1 and L*FADE_DIV cycles depending on prescaler phase.
- FADE_EN falling mid-fade: an LED that is off goes to level 0 on the next edge and LED_OUT to 0 one edge later.
- MAX_LEVEL=0 with s[i]=1: LED stays dark. This is legal and is not treated as a fade.
- Channels are fully independent; all 8 may fade simultaneously off the shared fade_tick.
- Reset mid-fade: everything returns immediately to the reset values above; no residual glow after reset.

Test Plan:
- Reset: RESET=0 with LED_IN=8'hFF → LED_OUT=8'h00 immediately (asynchronous), held until RESET=1.
- Full-on path: FADE_EN=1, MAX_LEVEL=15, LED_IN 8'h00→8'h81 before edge 0 → LED_OUT=8'h81 from edge 3, constant.
- PWM duty: MAX_LEVEL=5, LED_IN=8'h01 held → LED_OUT[0] high exactly 5 of every 15 cycles, at pwm_cnt 0–4.
- Fade (FADE_DIV=4 in bench): MAX_LEVEL=15, LED_IN[0] 1→0 → level steps 15→14→…→0, one step per 4 cycles; level 0 reached within 57–60 cycles; LED_OUT[0]=0 thereafter.
- Fade disabled and re-light: FADE_EN=0, LED_IN 8'hFF→8'h00 → LED_OUT=8'h00 at edge 3. Then FADE_EN=1 and LED_IN[3] re-asserted mid-fade at level 6 → level jumps to MAX_LEVEL at edge 2.
- Reset mid-fade: assert RESET=0 while level[2]=9 → LED_OUT=0 at once; after release with LED_IN=0, LED_OUT stays 8'h00.

Source files
------------

// File: rtl/led_fade_pwm.sv
// PWM brightness and afterglow fade for the red LED pattern.
// The slow-domain pattern is double-synchronized, and each channel keeps its own brightness level.
module led_fade_pwm #(
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned FADE_DIV = 1024
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [7:0]          LED_IN,
  input  logic [PWM_BITS-1:0] MAX_LEVEL,
  input  logic                FADE_EN,
  output logic [7:0]          LED_OUT
);

  localparam int unsigned N_LED = 8;
  localparam int unsigned DIV_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [N_LED-1:0]    sync1;
  logic [N_LED-1:0]    s;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [PWM_BITS-1:0] level     [N_LED];
  logic [PWM_BITS-1:0] level_nxt [N_LED];
  logic                fade_tick_c;

  assign fade_tick_c = (div_cnt == DIV_LAST);

  // Per-channel level update: lit tracks MAX_LEVEL, unlit clears or fades by one step per tick.
  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      level_nxt[i] = level[i];
      if (s[i]) begin
        level_nxt[i] = MAX_LEVEL;
      end else if (!FADE_EN) begin
        level_nxt[i] = '0;
      end else if (fade_tick_c && (level[i] != '0)) begin
        level_nxt[i] = level[i] - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1   <= '0;
      s       <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
      LED_OUT <= '0;
      for (int i = 0; i < int'(N_LED); i++) begin
        level[i] <= '0;
      end
    end else begin
      sync1   <= LED_IN;
      s       <= sync1;
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
      div_cnt <= fade_tick_c ? '0 : div_cnt + DIV_W'(1);
      for (int i = 0; i < int'(N_LED); i++) begin
        level[i]   <= level_nxt[i];
        LED_OUT[i] <= (pwm_cnt < level[i]);
      end
    end
  end

endmodule
